add_unit_arbiter: RTL

ADD_UNIT_ARBITER -- requirements
Module: add_unit_arbiter

---
 rtl/add_unit_arbiter.sv | 95 +++++++++
 1 files changed

// File: rtl/add_unit_arbiter.sv
// add_unit_arbiter: round-robin arbiter in front of one shared WIDTH-bit adder.
// Ports:
//   real_clk, real_rst    clock; asynchronous active-high reset
//   req[3:0]              per-requester add request, held until gnt
//   op_a, op_b            packed operands, requester i at [i*WIDTH +: WIDTH]
//   gnt[3:0]              registered one-hot grant pulse
//   busy                  high whenever the unit is not idle
//   res_valid, res_ready  result handshake
//   res_id, res_data      owner index and sum
//   res_carry             raw carry-out of the add
// Define ADD_UNIT_ARB_SAT_EN to saturate res_data to all-ones on carry-out.
module add_unit_arbiter #(
    parameter int WIDTH = 3
) (
    input  logic               real_clk,
    input  logic               real_rst,
    input  logic [3:0]         req,
    input  logic [4*WIDTH-1:0] op_a,
    input  logic [4*WIDTH-1:0] op_b,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [1:0]         res_id,
    output logic [WIDTH-1:0]   res_data,
    output logic               res_carry
);
    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
    state_t           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d, id_q, id_d, rid_q, rid_d, win;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, data_q, data_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             valid_q, valid_d, carry_q, carry_d, grant, exec;
    logic [WIDTH:0]   sum;
    always_ff @(posedge real_clk or posedge real_rst) begin
        if (real_rst) begin
            state_q <= IDLE;
            ptr_q   <= 2'd3;
            id_q    <= '0;
            rid_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            rid_q   <= rid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            data_q  <= data_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            carry_q <= carry_d;
        end
    end
    always_comb begin
        state_d = (state_q == IDLE) ? (|req ? EXEC : IDLE) :
                  (state_q == EXEC) ? DONE :
                  (res_ready ? IDLE : DONE);
    end
    // Scan from farthest to nearest so the nearest requester after ptr_q wins.
    always_comb begin
        win = ptr_q;
        for (int k = 4; k >= 1; k--)
            if (req[ptr_q + 2'(k)]) win = ptr_q + 2'(k);
    end
    always_comb begin
        grant   = (state_q == IDLE) && |req;
        exec    = (state_q == EXEC);
        sum     = {1'b0, a_q} + {1'b0, b_q};
        gnt_d   = grant ? 4'b0001 << win : 4'b0000;
        ptr_d   = grant ? win : ptr_q;
        id_d    = grant ? win : id_q;
        a_d     = grant ? op_a[win*WIDTH +: WIDTH] : a_q;
        b_d     = grant ? op_b[win*WIDTH +: WIDTH] : b_q;
        valid_d = exec ? 1'b1 : ((state_q == DONE) && res_ready) ? 1'b0 : valid_q;
        rid_d   = exec ? id_q : rid_q;
        carry_d = exec ? sum[WIDTH] : carry_q;
`ifdef ADD_UNIT_ARB_SAT_EN
        data_d  = exec ? (sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0]) : data_q;
`else
        data_d  = exec ? sum[WIDTH-1:0] : data_q;
`endif
        busy    = (state_q != IDLE);
    end
    assign gnt       = gnt_q;
    assign res_valid = valid_q;
    assign res_id    = rid_q;
    assign res_data  = data_q;
    assign res_carry = carry_q;
endmodule
